// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file writeback arbiter with a registered write port
// and round-robin contention resolution. Optional forwarding port: RF_WB_FWD_EN.
module rf_wb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        req0_valid,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic [4:0]  RdAddr,
    output logic [31:0] RdData,
    output logic        RegWrite,
    output logic [15:0] wr_count
`ifdef RF_WB_FWD_EN
    ,
    input  logic [4:0]  fwd_addr,
    output logic        fwd_hit,
    output logic [31:0] fwd_data
`endif
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t      state_reg, state_next;
    logic        ptr_reg, ptr_next;
    logic [4:0]  addr_reg, addr_next;
    logic [31:0] data_reg, data_next;
    logic [15:0] count_reg, count_next;

    logic        gnt0, gnt1, xfer, wr_xfer;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    // Grant logic; ready is suppressed during reset as well as on hold.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && !hold) begin
            if (req0_valid && req1_valid) begin
                gnt0 = ~ptr_reg;
                gnt1 = ptr_reg;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign xfer       = gnt0 | gnt1;
    assign sel_addr   = gnt1 ? req1_addr : req0_addr;
    assign sel_data   = gnt1 ? req1_data : req0_data;
    // Writes to register 0 are consumed but never reach the register file.
    assign wr_xfer    = xfer && (sel_addr != 5'd0);

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE:    state_next = wr_xfer ? WRITE : IDLE;
            WRITE:   state_next = wr_xfer ? WRITE : IDLE;
            default: state_next = IDLE;
        endcase
        if (xfer) begin
            ptr_next = gnt0;
        end
        if (wr_xfer) begin
            addr_next = sel_addr;
            data_next = sel_data;
            if (count_reg != 16'hFFFF) begin
                count_next = count_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= 1'b0;
            addr_reg  <= 5'd0;
            data_reg  <= 32'd0;
            count_reg <= 16'd0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            count_reg <= count_next;
        end
    end

    assign RdAddr   = addr_reg;
    assign RdData   = data_reg;
    assign RegWrite = (state_reg == WRITE);
    assign wr_count = count_reg;

`ifdef RF_WB_FWD_EN
    assign fwd_hit  = (state_reg == WRITE) && (fwd_addr == addr_reg) && (fwd_addr != 5'd0);
    assign fwd_data = fwd_hit ? data_reg : 32'd0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed bench for rf_wb_arbiter against a transaction-level
// model of grants, round-robin priority and the registered write port.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        h, v0, v1;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        r0, r1;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        reg_write;
    logic [15:0] cnt;
`ifdef RF_WB_FWD_EN
    logic [4:0]  fa;
    logic        fhit;
    logic [31:0] fdata;
`endif

    rf_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n), .hold(h),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1),
        .RdAddr(rd_addr), .RdData(rd_data), .RegWrite(reg_write), .wr_count(cnt)
`ifdef RF_WB_FWD_EN
        , .fwd_addr(fa), .fwd_hit(fhit), .fwd_data(fdata)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference state: who has priority and what the write port should show.
    int          prio;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [15:0] exp_cnt;
    logic        g0, g1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        prio = 0; exp_we = 1'b0; exp_addr = 5'd0; exp_data = 32'd0; exp_cnt = 16'd0;
        g0 = 1'b0; g1 = 1'b0;
    endtask

    // Asserts reset mid-cycle; outputs must clear without any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_regwrite", {31'd0, reg_write}, 32'd0);
        check("rst_rdaddr", {27'd0, rd_addr}, 32'd0);
        check("rst_rddata", rd_data, 32'd0);
        check("rst_count", {16'd0, cnt}, 32'd0);
        check("rst_ready0", {31'd0, r0}, 32'd0);
        check("rst_ready1", {31'd0, r1}, 32'd0);
        h = 1'b0; v0 = 1'b0; v1 = 1'b0; a0 = 5'd0; a1 = 5'd0; d0 = 32'd0; d1 = 32'd0;
`ifdef RF_WB_FWD_EN
        fa = 5'd0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: called at posedge+1 with inputs already applied.
    task automatic cycle(input bit quiet);
        logic       e0, e1;
        logic [4:0] wa;
        e0 = 1'b0;
        e1 = 1'b0;
        #3;
        if (!h) begin
            if (v0 && v1) begin
                e0 = (prio == 0);
                e1 = (prio == 1);
            end else begin
                e0 = v0;
                e1 = v1;
            end
        end
        if (!quiet) begin
            check("ready0", {31'd0, r0}, {31'd0, e0});
            check("ready1", {31'd0, r1}, {31'd0, e1});
`ifdef RF_WB_FWD_EN
            check("fwd_hit", {31'd0, fhit}, {31'd0, exp_we && fa == exp_addr && fa != 5'd0});
            check("fwd_data", fdata, (exp_we && fa == exp_addr && fa != 5'd0) ? exp_data : 32'd0);
`endif
        end
        @(posedge clk);
        g0 = e0;
        g1 = e1;
        exp_we = 1'b0;
        if (e0 || e1) begin
            prio = e0 ? 1 : 0;
            wa = e0 ? a0 : a1;
            if (wa != 5'd0) begin
                exp_we = 1'b1;
                exp_addr = wa;
                exp_data = e0 ? d0 : d1;
                if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            end
        end
        #1;
        if (!quiet) begin
            check("regwrite", {31'd0, reg_write}, {31'd0, exp_we});
            check("rdaddr", {27'd0, rd_addr}, {27'd0, exp_addr});
            check("rddata", rd_data, exp_data);
            check("wr_count", {16'd0, cnt}, {16'd0, exp_cnt});
            $display("cyc t=%0t hold=%b v=%b%b g=%b%b we=%b addr=%0d data=%h cnt=%0d",
                     $time, h, v1, v0, r1, r0, reg_write, rd_addr, rd_data, cnt);
        end
    endtask

    initial begin
        h = 1'b0; v0 = 1'b0; v1 = 1'b0; a0 = 5'd0; a1 = 5'd0; d0 = 32'd0; d1 = 32'd0;
`ifdef RF_WB_FWD_EN
        fa = 5'd0;
`endif
        #2;
        do_reset();

        // Single requester, same-cycle grant, one-cycle write latency.
        v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEADBEEF;
        cycle(0);
        check("first_addr", {27'd0, rd_addr}, 32'd5);
        check("first_data", rd_data, 32'hDEADBEEF);
        check("first_count", {16'd0, cnt}, 32'd1);
        v0 = 1'b0;
        cycle(0);

        // Contention after reset: grants 0,1,0 then priority sits with 1.
        do_reset();
        v0 = 1'b1; a0 = 5'd1; d0 = 32'h1111_0001;
        v1 = 1'b1; a1 = 5'd2; d1 = 32'h2222_0002;
        repeat (3) cycle(0);
        check("rr_last_addr", {27'd0, rd_addr}, 32'd1);
        cycle(0);
        check("rr_ptr1_addr", {27'd0, rd_addr}, 32'd2);
        v0 = 1'b0; v1 = 1'b0;
        cycle(0);

        // Register 0 is consumed but not written.
        v1 = 1'b1; a1 = 5'd0; d1 = 32'h1234;
        cycle(0);
        check("zero_regwrite", {31'd0, reg_write}, 32'd0);
        v1 = 1'b0;
        cycle(0);

        // Hold: pending write completes, nothing granted while held.
        v0 = 1'b1; a0 = 5'd9; d0 = 32'h0909_0909;
        cycle(0);
        h = 1'b1; v1 = 1'b1; a1 = 5'd10; d1 = 32'h0A0A_0A0A;
        cycle(0);
        cycle(0);
        h = 1'b0;
        cycle(0);
        v0 = 1'b0; v1 = 1'b0;
        cycle(0);

`ifdef RF_WB_FWD_EN
        v0 = 1'b1; a0 = 5'd7; d0 = 32'hA5A5A5A5;
        cycle(0);
        v0 = 1'b0;
        fa = 5'd7;
        #1;
        check("fwd7_hit", {31'd0, fhit}, 32'd1);
        check("fwd7_data", fdata, 32'hA5A5A5A5);
        fa = 5'd0;
        #1;
        check("fwd0_hit", {31'd0, fhit}, 32'd0);
        check("fwd0_data", fdata, 32'd0);
        cycle(0);
`endif

        // Asynchronous reset while a write is on the port.
        v0 = 1'b1; a0 = 5'd3; d0 = 32'h3333_3333;
        cycle(0);
        #2;
        do_reset();

        // Randomized traffic; a losing requester keeps its request stable.
        for (int i = 0; i < 400; i++) begin
            if (!v0 || g0) begin
                v0 = ($urandom % 4) != 0;
                a0 = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom % 32);
                d0 = $urandom;
            end
            if (!v1 || g1) begin
                v1 = ($urandom % 4) != 0;
                a1 = (($urandom % 4) == 0) ? a0 : 5'($urandom % 32);
                d1 = $urandom;
            end
            h = ($urandom % 5) == 0;
`ifdef RF_WB_FWD_EN
            fa = ($urandom % 2) ? exp_addr : 5'($urandom % 32);
`endif
            cycle(0);
        end

        // wr_count saturation.
        do_reset();
        v0 = 1'b1; a0 = 5'd1; d0 = 32'h5A5A_0001;
        repeat (65540) cycle(1);
        check("sat_count", {16'd0, cnt}, 32'h0000FFFF);
        cycle(0);
        v0 = 1'b0;
        cycle(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
